pipelined_addsub: RTL and testbench
===================================

PIPELINED_ADDSUB -- requirements
Module: pipelined_addsub

Interface
REQ-001 Parameter WIDTH, default 8: operand/sum width in bits; legal range 2..64.
REQ-002 Parameter STAGES, default 2: number of carry-chain pipeline segments; legal range 1..WIDTH; WIDTH % STAGES == 0 SHALL hold, else elaboration error.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 a, b  input  WIDTH each  operands.
REQ-008 cin  input  1  carry-in; used in add mode only.
REQ-009 sub  input  1  0 = add, 1 = subtract.
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 sum  output  WIDTH  result bits.
REQ-013 cout  output  1  carry-out of MSB (subtract: 1 = no borrow).
REQ-014 ovf  output  1  two's-complement signed overflow.

Function
REQ-015 SEG = WIDTH/STAGES; stage k (0..STAGES-1) SHALL add bits [k*SEG +: SEG] using the carry registered by stage k-1 (stage 0 uses the effective carry-in).
REQ-016 Add: {cout,sum} = a + b + cin; subtract: {cout,sum} = a + ~b + 1, cin ignored.
REQ-017 ovf = carry into MSB XOR carry out of MSB, computed in the final stage.
REQ-018 Not-yet-consumed operand slices SHALL be skew-registered per stage; completed sum slices SHALL be deskewed so all WIDTH sum bits emerge in the same beat.
REQ-019 A beat transfers in when in_valid && in_ready, out when out_valid && out_ready.
REQ-020 Latency: a beat accepted at edge N SHALL present out_valid, sum, cout, ovf after edge N+STAGES-1 (STAGES=1: registered on the accept edge, visible the following cycle).
REQ-021 in_ready = out_ready || !out_valid (global stall); combinational, no path from in_valid.
REQ-022 When in_ready = 0, every stage register, valid bit, and output SHALL hold.
REQ-023 When in_ready = 1 and in_valid = 0, a bubble (valid=0) SHALL enter stage 0; bubbles are not compressed.
REQ-024 sum, cout, ovf SHALL remain stable while out_valid && !out_ready.
REQ-025 Throughput SHALL be one beat per cycle when out_ready is held 1.
REQ-026 Simultaneous output consume and input accept in one cycle SHALL be lossless.
REQ-027 Operand values with in_valid = 0 SHALL NOT affect any output.

Reset
REQ-028 While rst_n = 0, all stage valid bits, out_valid, sum, cout, ovf SHALL be 0, independent of clk.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight beats; none emerge after release.
REQ-030 in_ready SHALL be 1 from the first cycle after rst_n deasserts.

Structure
REQ-031 Shared package pipelined_addsub_pkg SHALL hold mode constants (MODE_ADD = 0, MODE_SUB = 1) and the stage-record typedef (valid, carry, skewed operands, partial sum).
REQ-032 One sub-module, addsub_segment, SHALL be a purely combinational SEG-bit ripple add with carry-in/out and MSB carry-in export, instantiated STAGES times via generate.
REQ-033 Only stage registers and the output register SHALL be sequential; no latches.

Verification (WIDTH=8, STAGES=2 unless noted)
REQ-034 a=0xFF, b=0x01, cin=0, sub=0, out_ready=1 -> two cycles later sum=0x00, cout=1, ovf=0.
REQ-035 a=0x7F, b=0x01, cin=0, sub=0 -> sum=0x80, cout=0, ovf=1; a=0x05, b=0x07, sub=1, cin=1 -> sum=0xFE, cout=0, ovf=0.
REQ-036 Back-to-back 16 beats a=i, b=2i with out_ready low on cycles 3-6 -> in_ready low those cycles, outputs held stable, all 16 results 3i in order, none lost or duplicated.
REQ-037 rst_n pulsed low with two beats in flight -> out_valid=0 and outputs 0 immediately; no stale beat after release; in_ready=1 next cycle.
REQ-038 WIDTH=16, STAGES=1 and WIDTH=16, STAGES=16: 10,000 random beats with random valid/ready -> every result matches reference model; latency equals STAGES.

Source files
------------

// File: rtl/pipelined_addsub_pkg.sv
// Shared types for the pipelined add/subtract block: mode encoding and the
// per-stage record that carries operands, carry and partial sum down the pipe.
package pipelined_addsub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Widest supported operand; narrower instances leave the upper bits at zero.
  localparam int MAX_W = 64;

  typedef struct packed {
    logic             vld;
    logic             carry;
    logic [MAX_W-1:0] a;
    logic [MAX_W-1:0] b;
    logic [MAX_W-1:0] sum;
  } stage_t;

endpackage

// File: rtl/addsub_segment.sv
// One carry-chain segment: SEG-bit ripple add with carry in/out, plus the
// carry into its MSB so the last segment can form signed overflow.
module addsub_segment
  import pipelined_addsub_pkg::*;
#(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           msb_ci
);

  always_comb begin
    {co, s} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};
    // sum bit = a ^ b ^ carry-in, so the MSB carry-in falls out directly
    msb_ci  = a[SEG-1] ^ b[SEG-1] ^ s[SEG-1];
  end

endmodule

// File: rtl/pipelined_addsub.sv
// Carry-chain pipelined adder/subtractor: STAGES segments of WIDTH/STAGES bits,
// operands skewed into later stages, sum slices collected so they exit together.
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG = WIDTH / STAGES;

  if (WIDTH < 2 || WIDTH > MAX_W || STAGES < 1 || STAGES > WIDTH ||
      (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_addsub: illegal WIDTH/STAGES combination");
  end

  stage_t                       seg_in [STAGES];
  stage_t                       stg_d  [STAGES];
  stage_t                       stg_q  [STAGES];
  logic [STAGES-1:0][SEG-1:0]   seg_s;
  logic [STAGES-1:0]            seg_co;
  logic [STAGES-1:0]            seg_mci;
  logic                         ovf_d, ovf_q;
  logic                         unused_last;

  // Global stall: the whole pipe advances only when the output slot frees up.
  assign in_ready = out_ready || !out_valid;

  always_comb begin
    seg_in[0]     = '0;
    seg_in[0].vld = in_valid;
    // Bubbles carry all-zero operands so idle bus values never reach outputs.
    if (in_valid) begin
      seg_in[0].carry = (sub == MODE_SUB) ? 1'b1 : cin;
      seg_in[0].a     = MAX_W'(a);
      seg_in[0].b     = MAX_W'((sub == MODE_SUB) ? ~b : b);
    end
    for (int k = 1; k < STAGES; k++) seg_in[k] = stg_q[k-1];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    addsub_segment #(.SEG(SEG)) u_seg (
      .a      (seg_in[k].a[k*SEG +: SEG]),
      .b      (seg_in[k].b[k*SEG +: SEG]),
      .ci     (seg_in[k].carry),
      .s      (seg_s[k]),
      .co     (seg_co[k]),
      .msb_ci (seg_mci[k])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      stg_d[k]                   = seg_in[k];
      stg_d[k].sum[k*SEG +: SEG] = seg_s[k];
      stg_d[k].carry             = seg_co[k];
    end
    ovf_d = seg_co[STAGES-1] ^ seg_mci[STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) stg_q[k] <= '0;
      ovf_q <= 1'b0;
    end else if (in_ready) begin
      for (int k = 0; k < STAGES; k++) stg_q[k] <= stg_d[k];
      ovf_q <= ovf_d;
    end
  end

  // The last stage register doubles as the output register.
  assign out_valid = stg_q[STAGES-1].vld;
  assign sum       = stg_q[STAGES-1].sum[WIDTH-1:0];
  assign cout      = stg_q[STAGES-1].carry;
  assign ovf       = ovf_q;

  assign unused_last = ^{stg_q[STAGES-1].a, stg_q[STAGES-1].b, stg_q[STAGES-1].sum};

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed 8-bit/2-stage checks plus random traffic
// on 16-bit 1-stage and 16-stage instances against an arithmetic reference.
module tb_pipelined_addsub;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  a8, b8, s8;
  logic        cin8, sub8, iv8, ordy8, rdy8, ov8, co8, of8;
  logic [15:0] a16, b16;
  logic        cin16, sub16, iv16, ordy16;
  logic        rdy16 [2];
  logic        ov16  [2];
  logic        co16  [2];
  logic        of16  [2];
  logic [15:0] s16   [2];

  int   ncmp = 0;
  int   nerr = 0;
  exp_t q0[$], q1[$], q2[$];
  int   acc16 [2];
  int   rx8;
  bit   seq_chk;
  bit   held_v [3];
  exp_t held_e [3];

  pipelined_addsub #(.WIDTH(8), .STAGES(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(rdy8), .a(a8), .b(b8),
    .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(ordy8), .sum(s8),
    .cout(co8), .ovf(of8));

  pipelined_addsub #(.WIDTH(16), .STAGES(1)) u_dut16s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(rdy16[0]), .a(a16), .b(b16),
    .cin(cin16), .sub(sub16), .out_valid(ov16[0]), .out_ready(ordy16), .sum(s16[0]),
    .cout(co16[0]), .ovf(of16[0]));

  pipelined_addsub #(.WIDTH(16), .STAGES(16)) u_dut16s16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(rdy16[1]), .a(a16), .b(b16),
    .cin(cin16), .sub(sub16), .out_valid(ov16[1]), .out_ready(ordy16), .sum(s16[1]),
    .cout(co16[1]), .ovf(of16[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic exp_t model(input int w, input longint ua, input longint ub,
                                 input logic ci, input logic sub_i);
    longint full, sa, sb, r, lim;
    exp_t   e;
    lim = longint'(1) << (w - 1);
    sa  = (ua >= lim) ? ua - 2 * lim : ua;
    sb  = (ub >= lim) ? ub - 2 * lim : ub;
    if (!sub_i) begin
      full   = ua + ub + longint'(ci);
      r      = sa + sb + longint'(ci);
      e.cout = (full >= 2 * lim);
    end else begin
      full   = ua - ub;
      r      = sa - sb;
      e.cout = (ua >= ub);
    end
    e.sum = 16'(full & (2 * lim - 1));
    e.ovf = (r >= lim) || (r < -lim);
    return e;
  endfunction

  task automatic chk_out(input int i, input string tag, input logic [15:0] s,
                         input logic co, input logic of);
    exp_t e;
    int   n;
    n = (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
    ncmp++;
    assert (n > 0) else begin
      nerr++;
      $error("FAIL %s_spurious observed=beat sum %0h expected=no beat", tag, s);
    end
    if (n > 0) begin
      if (i == 0) e = q0.pop_front();
      else if (i == 1) e = q1.pop_front();
      else e = q2.pop_front();
      chk({tag, "_sum"},  32'(s),  32'(e.sum));
      chk({tag, "_cout"}, 32'(co), 32'(e.cout));
      chk({tag, "_ovf"},  32'(of), 32'(e.ovf));
    end
  endtask

  task automatic hold_chk(input int i, input string tag, input logic v, input logic r,
                          input logic [15:0] s, input logic co, input logic of);
    if (held_v[i] && v) begin
      chk({tag, "_sum"},  32'(s),  32'(held_e[i].sum));
      chk({tag, "_cout"}, 32'(co), 32'(held_e[i].cout));
      chk({tag, "_ovf"},  32'(of), 32'(held_e[i].ovf));
    end
    held_v[i] = v && !r;
    held_e[i] = '{sum: s, cout: co, ovf: of};
  endtask

  // One clock: check outputs, record accepted beats, advance past the edge.
  task automatic step();
    #1;
    hold_chk(0, "hold8",    ov8,     ordy8,  16'(s8), co8,     of8);
    hold_chk(1, "hold16s1", ov16[0], ordy16, s16[0],  co16[0], of16[0]);
    hold_chk(2, "hold16s16", ov16[1], ordy16, s16[1], co16[1], of16[1]);
    if (ov8 && ordy8) begin
      if (seq_chk) chk("order8", 32'(s8), 32'(3 * rx8));
      rx8++;
      chk_out(0, "out8", 16'(s8), co8, of8);
    end
    if (ov16[0] && ordy16) chk_out(1, "out16s1",  s16[0], co16[0], of16[0]);
    if (ov16[1] && ordy16) chk_out(2, "out16s16", s16[1], co16[1], of16[1]);
    if (iv8 && rdy8) q0.push_back(model(8, longint'(a8), longint'(b8), cin8, sub8));
    if (iv16 && rdy16[0]) begin
      q1.push_back(model(16, longint'(a16), longint'(b16), cin16, sub16));
      acc16[0]++;
    end
    if (iv16 && rdy16[1]) begin
      q2.push_back(model(16, longint'(a16), longint'(b16), cin16, sub16));
      acc16[1]++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic flush_model();
    q0.delete(); q1.delete(); q2.delete();
    for (int i = 0; i < 3; i++) held_v[i] = 1'b0;
  endtask

  initial begin
    int idx, cyc;
    int lat [2];
    bit acc;
    a8 = '0; b8 = '0; cin8 = 0; sub8 = 0; iv8 = 0; ordy8 = 1;
    a16 = '0; b16 = '0; cin16 = 0; sub16 = 0; iv16 = 0; ordy16 = 1;
    acc16[0] = 0; acc16[1] = 0; rx8 = 0; seq_chk = 0;
    flush_model();

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid8", 32'(ov8), 32'(0));
    chk("rst_sum8",       32'(s8),  32'(0));
    chk("rst_cout8",      32'(co8), 32'(0));
    chk("rst_ovf8",       32'(of8), 32'(0));
    for (int i = 0; i < 2; i++) chk("rst_out_valid16", 32'(ov16[i]), 32'(0));
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_init", 32'(rdy8), 32'(1));

    // 0xFF + 0x01
    iv8 = 1; a8 = 8'hFF; b8 = 8'h01; cin8 = 0; sub8 = 0;
    step();
    iv8 = 0;
    step();
    chk("wrap_valid", 32'(ov8), 32'(1));
    chk("wrap_sum",   32'(s8),  32'(8'h00));
    chk("wrap_cout",  32'(co8), 32'(1));
    chk("wrap_ovf",   32'(of8), 32'(0));
    repeat (3) step();

    // Signed overflow on add, then subtract with cin ignored
    iv8 = 1; a8 = 8'h7F; b8 = 8'h01; cin8 = 0; sub8 = 0;
    step();
    a8 = 8'h05; b8 = 8'h07; cin8 = 1; sub8 = 1;
    step();
    chk("addovf_sum",  32'(s8),  32'(8'h80));
    chk("addovf_cout", 32'(co8), 32'(0));
    chk("addovf_ovf",  32'(of8), 32'(1));
    iv8 = 0; cin8 = 0; sub8 = 0;
    step();
    chk("sub_sum",  32'(s8),  32'(8'hFE));
    chk("sub_cout", 32'(co8), 32'(0));
    chk("sub_ovf",  32'(of8), 32'(0));
    repeat (3) step();

    // 16 back-to-back beats with a 4-cycle downstream stall
    idx = 0; rx8 = 0; seq_chk = 1;
    for (int c = 0; c < 40; c++) begin
      iv8 = (idx < 16); a8 = 8'(idx); b8 = 8'(2 * idx); cin8 = 0; sub8 = 0;
      ordy8 = !(c >= 3 && c <= 6);
      #1;
      if (idx < 16) chk("stall_in_ready", 32'(rdy8), 32'(!(c >= 3 && c <= 6)));
      acc = iv8 && rdy8;
      step();
      if (acc) idx++;
    end
    seq_chk = 0;
    chk("stall_rx_count", 32'(rx8), 32'(16));
    chk("stall_leftover", 32'(q0.size()), 32'(0));
    iv8 = 0; ordy8 = 1;

    // Reset with two beats in flight
    iv8 = 1; a8 = 8'h10; b8 = 8'h20;
    step();
    a8 = 8'h30; b8 = 8'h40;
    step();
    iv8 = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(ov8), 32'(0));
    chk("midrst_sum",       32'(s8),  32'(0));
    chk("midrst_cout",      32'(co8), 32'(0));
    chk("midrst_ovf",       32'(of8), 32'(0));
    flush_model();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready", 32'(rdy8), 32'(1));
    repeat (5) begin
      step();
      chk("midrst_stale", 32'(ov8), 32'(0));
    end

    // Latency on the 16-bit instances
    iv16 = 1; a16 = 16'h1234; b16 = 16'h0F0F; cin16 = 1; sub16 = 0; ordy16 = 1;
    lat[0] = 0; lat[1] = 0;
    step();
    iv16 = 0;
    for (int l = 1; l < 40; l++) begin
      for (int i = 0; i < 2; i++) if (ov16[i] && lat[i] == 0) lat[i] = l;
      step();
    end
    chk("latency16s1",  32'(lat[0]), 32'(1));
    chk("latency16s16", 32'(lat[1]), 32'(16));

    // Random traffic with random valid/ready
    acc16[0] = 0; acc16[1] = 0; cyc = 0;
    while ((acc16[0] < 10000 || acc16[1] < 10000) && cyc < 40000) begin
      iv16   = ($urandom_range(0, 9) < 7);
      a16    = 16'($urandom);
      b16    = 16'($urandom);
      cin16  = 1'($urandom);
      sub16  = 1'($urandom);
      ordy16 = ($urandom_range(0, 9) < 7);
      step();
      cyc++;
    end
    chk("random_budget", 32'(cyc < 40000), 32'(1));
    iv16 = 0; ordy16 = 1;
    repeat (40) step();
    chk("drain16s1",  32'(q1.size()), 32'(0));
    chk("drain16s16", 32'(q2.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
